// File: rtl/shift_normalizer.sv
// Sequential normalizer: shifts an operand one position per cycle until the target bit is 1.
// Optional SHIFT_NORM_FAST_EN enables two-position steps while the two nearest bits are zero.
module shift_normalizer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic             dir_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] y_o,
  output logic [AMT_W-1:0] amt_o,
  output logic             zero_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [AMT_W-1:0] CNT_MAX = AMT_W'(WIDTH - 1);
  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             zr_q, zr_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             tgt_bit;
  logic             stop;
  logic             load_res;

`ifdef SHIFT_NORM_FAST_EN
  localparam logic [AMT_W-1:0] CNT_FAST_MAX = AMT_W'(WIDTH - 3);
  localparam logic [AMT_W-1:0] CNT_TWO      = AMT_W'(2);
  logic [1:0] near2;
  logic       fast_ok;
`endif

  assign tgt_bit = dir_q ? sr_q[0] : sr_q[WIDTH-1];
  assign stop    = zr_q | tgt_bit | (cnt_q == CNT_MAX);

`ifdef SHIFT_NORM_FAST_EN
  assign near2   = dir_q ? sr_q[1:0] : sr_q[WIDTH-1:WIDTH-2];
  assign fast_ok = (near2 == 2'b00) && (cnt_q <= CNT_FAST_MAX);
`endif

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    zr_d    = zr_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          sr_d    = a_i;
          dir_d   = dir_i;
          cnt_d   = '0;
          zr_d    = (a_i == '0);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (stop) begin
          state_d = DONE;
`ifdef SHIFT_NORM_FAST_EN
        end else if (fast_ok) begin
          sr_d  = dir_q ? {2'b00, sr_q[WIDTH-1:2]} : {sr_q[WIDTH-3:0], 2'b00};
          cnt_d = cnt_q + CNT_TWO;
`endif
        end else begin
          sr_d  = dir_q ? {1'b0, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result registers capture on the SHIFT->DONE transition and hold until the next one.
  always_comb begin
    load_res = (state_q == SHIFT) && (state_d == DONE);
    y_d      = load_res ? sr_q : y_q;
    amt_d    = load_res ? cnt_q : amt_q;
    zero_d   = load_res ? zr_q : zero_q;
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      zr_q    <= 1'b0;
      y_q     <= '0;
      amt_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      zr_q    <= zr_d;
      y_q     <= y_d;
      amt_q   <= amt_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign y_o    = y_q;
  assign amt_o  = amt_q;
  assign zero_o = zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// Self-checking bench for shift_normalizer: directed table, corner sequences, random vs. model.
module tb_shift_normalizer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic       dir;
  logic       busy, done, zero;
  logic [7:0] y;
  logic [2:0] amt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_normalizer #(.WIDTH(8), .AMT_W(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(start),
    .a_i    (a),
    .dir_i  (dir),
    .busy_o (busy),
    .done_o (done),
    .y_o    (y),
    .amt_o  (amt),
    .zero_o (zero)
  );

  typedef struct {
    logic [7:0] a;
    logic       dir;
    logic [7:0] y;
    int         amt;
    logic       zero;
    int         lat_slow;
    int         lat_fast;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: apply the normalization rule on whole values; count cycles spent in SHIFT.
  task automatic model(input logic [7:0] av, input logic d, output logic [7:0] ry,
                       output int ramt, output logic rz, output int rlat);
    int steps;
    logic [7:0] v;
    v = av; ramt = 0; steps = 0; rz = (av == 8'h00);
    if (!rz) begin
      while (((d ? v[0] : v[7]) == 1'b0) && ramt < 7) begin
`ifdef SHIFT_NORM_FAST_EN
        if (((d ? (v & 8'h03) : (v & 8'hC0)) == 8'h00) && ramt <= 5) begin
          v = d ? (v >> 2) : (v << 2);
          ramt += 2;
        end else begin
          v = d ? (v >> 1) : (v << 1);
          ramt += 1;
        end
`else
        v = d ? (v >> 1) : (v << 1);
        ramt += 1;
`endif
        steps++;
      end
    end
    ry = v;
    rlat = steps + 2;
  endtask

  // Issues one operation; optionally re-asserts start with 0xFF while busy.
  task automatic do_op(input logic [7:0] av, input logic d, input bit poke,
                       output int lat, output bit busy_ok);
    @(negedge clk);
    a = av; dir = d; start = 1'b1;
    @(posedge clk); #1;
    lat = 1; busy_ok = 1;
    if (poke) begin a = 8'hFF; dir = ~d; end
    else start = 1'b0;
    while (!done && lat < 20) begin
      if (!busy) busy_ok = 0;
      @(posedge clk); #1;
      lat++;
      if (poke && lat >= 3) start = 1'b0;
    end
    start = 1'b0;
    if (!busy) busy_ok = 0;
  endtask

  task automatic post_done(input string name);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, int'(done), 0);
    chk({name, "_busy_fall"}, int'(busy), 0);
  endtask

  task automatic run_check(input string name, input logic [7:0] av, input logic d, input bit poke,
                           input logic [7:0] ey, input int eamt, input logic ez, input int elat);
    int lat;
    bit bok;
    do_op(av, d, poke, lat, bok);
    chk({name, "_lat"}, lat, elat);
    chk({name, "_y"}, int'(y), int'(ey));
    chk({name, "_amt"}, int'(amt), eamt);
    chk({name, "_zero"}, int'(zero), int'(ez));
    chk({name, "_busy"}, int'(bok), 1);
    post_done(name);
  endtask

  vec_t tbl[8];

  initial begin
    logic [7:0] my;
    int mamt, mlat;
    logic mz;

    tbl[0] = '{8'h13, 1'b0, 8'h98, 3, 1'b0, 5, 4};
    tbl[1] = '{8'h80, 1'b1, 8'h01, 7, 1'b0, 9, 6};
    tbl[2] = '{8'h00, 1'b0, 8'h00, 0, 1'b1, 2, 2};
    tbl[3] = '{8'h00, 1'b1, 8'h00, 0, 1'b1, 2, 2};
    tbl[4] = '{8'h01, 1'b0, 8'h80, 7, 1'b0, 9, 6};
    tbl[5] = '{8'h80, 1'b0, 8'h80, 0, 1'b0, 2, 2};
    tbl[6] = '{8'h01, 1'b1, 8'h01, 0, 1'b0, 2, 2};
    tbl[7] = '{8'hF0, 1'b1, 8'h0F, 4, 1'b0, 6, 4};

    rst_n = 1'b0; start = 1'b0; a = 8'h00; dir = 1'b0;
    #22;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_amt", int'(amt), 0);
    chk("rst_zero", int'(zero), 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
`ifdef SHIFT_NORM_FAST_EN
      run_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].dir, 1'b0,
                tbl[i].y, tbl[i].amt, tbl[i].zero, tbl[i].lat_fast);
`else
      run_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].dir, 1'b0,
                tbl[i].y, tbl[i].amt, tbl[i].zero, tbl[i].lat_slow);
`endif
    end

    // Start held with a different operand while busy must not disturb the result.
`ifdef SHIFT_NORM_FAST_EN
    run_check("poke", 8'h13, 1'b0, 1'b1, 8'h98, 3, 1'b0, 4);
`else
    run_check("poke", 8'h13, 1'b0, 1'b1, 8'h98, 3, 1'b0, 5);
`endif
    // Immediately following start (cycle after done) is accepted.
`ifdef SHIFT_NORM_FAST_EN
    run_check("b2b", 8'h01, 1'b0, 1'b0, 8'h80, 7, 1'b0, 6);
`else
    run_check("b2b", 8'h01, 1'b0, 1'b0, 8'h80, 7, 1'b0, 9);
`endif

    // Asynchronous reset in the third SHIFT cycle.
    @(negedge clk);
    a = 8'h01; dir = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy_pre", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_y", int'(y), 0);
    chk("mid_rst_amt", int'(amt), 0);
    chk("mid_rst_zero", int'(zero), 0);
    @(negedge clk); rst_n = 1'b1;
    run_check("after_rst", 8'h80, 1'b0, 1'b0, 8'h80, 0, 1'b0, 2);

    for (int i = 0; i < 150; i++) begin
      logic [7:0] ra;
      logic       rd;
      ra = 8'($urandom_range(0, 255)) >> $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) ra = ra << $urandom_range(0, 7);
      rd = 1'($urandom_range(0, 1));
      model(ra, rd, my, mamt, mz, mlat);
      run_check($sformatf("rnd%0d", i), ra, rd, 1'($urandom_range(0, 3) == 0),
                my, mamt, mz, mlat);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
